count_run_sequencer: RTL and testbench
======================================

Name: count_run_sequencer

Overview:
- Run/pause/clear sequencer for the 4-digit BCD counter chain that counts 0000 to 9675.
- Turns start/stop/clear commands into a rate-limited count-enable pulse and a counter clear, and watches the counter value for the terminal code 9675.
- On terminal, freezes counting and generates the blink pattern for the display.
- Sits between the user-command logic and counters_controller; cnt_ena drives its ena input, cnt_rst drives its rst input, qdata is fed back from its Qdata output.

Parameters:
TICK_DIV, 4, clock cycles per count step (>=2); sim default is small, synthesis overrides it.
BLINK_DIV, 8, clock cycles per blink phase in DONE (>=2).
TERMINAL, 16'h9675, BCD terminal value that stops counting.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  level; request run.
stop  input  1  level; request pause.
clear  input  1  level; request counter clear and return to IDLE.
qdata  input  16  current BCD counter value (4 digits, digit 3 in [15:12]).
cnt_ena  output  1  one-cycle count-step pulse to counter.
cnt_rst  output  1  clear pulse to counter.
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
done  output  1  high while in DONE.
blink  output  4  per-digit blank mask (1 = digit blanked).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - state=IDLE, cnt_ena=0, cnt_rst=1, done=0, blink=4'b0000.
  - Prescaler and blink counters are 0.
  - cnt_rst stays 1 for every cycle rst is high and drops the first cycle after rst is low, unless clear is high.
- Command priority within a cycle: clear > stop > start.
- State transitions (next state):
  - IDLE: clear -> IDLE, with cnt_rst=1 next cycle. start -> RUN. Otherwise hold.
  - RUN: clear -> IDLE with cnt_rst. stop -> PAUSE. qdata==TERMINAL -> DONE. Otherwise hold.
  - PAUSE: clear -> IDLE with cnt_rst. start (with stop low) -> RUN. Otherwise hold.
  - DONE: clear -> IDLE with cnt_rst. start and stop are ignored.
- cnt_rst: equals 1 in the cycle after any cycle where rst or clear is sampled high. A held clear gives a held cnt_rst.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while state==RUN, wrapping to 0.
  - Forced to 0 in every other state, so a resume always starts a full period.
- cnt_ena:
  - Set to 1 for exactly one cycle following a cycle where all hold: state==RUN, prescaler==TICK_DIV-1, qdata!=TERMINAL, clear=0, stop=0.
  - Otherwise 0.
  - First cnt_ena after entering RUN appears TICK_DIV cycles after the first RUN cycle.
- Terminal:
  - Equality compare on the full 16 bits.
  - No cnt_ena is issued once qdata==TERMINAL, even if the tick coincides.
  - RUN->DONE happens on the cycle qdata first matches.
- done: equals (state==DONE), registered with the state.
- Blink:
  - The blink counter runs only in DONE, counting 0..BLINK_DIV-1 and toggling a phase bit at wrap.
  - Phase starts at 1 on entry to DONE, so blink=4'b1111 on the first DONE cycle.
  - blink=4'b1111 when phase=1, 4'b0000 when phase=0.
  - blink=0 and counter/phase reset in every other state.
- qdata values above TERMINAL or non-BCD are not checked; the sequencer keeps running until the match or a command.
- Reset mid-operation: returns to reset values on the next edge regardless of state or pending commands.

Test Plan:
- Reset and start, with TICK_DIV=4. Hold rst 3 cycles, release, pulse start 1 cycle -> cnt_rst=1 during reset then 0; state=01 next cycle; cnt_ena pulses every 4 cycles with the first pulse 4 cycles after entering RUN.
- Pause/resume. In RUN, assert stop 1 cycle -> state=10, no cnt_ena while paused; start -> state=01, next cnt_ena exactly 4 cycles later.
- Terminal. Drive qdata=16'h9674, then 16'h9675 in the same cycle as prescaler==3 -> no cnt_ena; state=11, done=1; blink=1111 for 8 cycles, 0000 for 8, repeating; start has no effect.
- Clear priority. Assert start, stop and clear together in RUN -> state=00, cnt_rst=1 one cycle later, cnt_ena=0.
- Held clear in DONE for 5 cycles -> cnt_rst high 5 cycles (lagged by one); blink=0000 and done=0 after the first edge.
- Reset mid-RUN, with rst for 1 cycle at prescaler==2 -> state=00 and cnt_ena=0; after a new start, the first cnt_ena comes a full 4 cycles after entering RUN.

Source files
------------

// File: rtl/count_run_sequencer.sv
// Run/pause/clear sequencer for the BCD counter chain: rate-limited count enable,
// counter clear, terminal detection and the DONE blink pattern.
module count_run_sequencer #(
  parameter int          TICK_DIV  = 4,
  parameter int          BLINK_DIV = 8,
  parameter logic [15:0] TERMINAL  = 16'h9675
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] qdata,
  output logic        cnt_ena,
  output logic        cnt_rst,
  output logic [1:0]  state,
  output logic        done,
  output logic [3:0]  blink
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          cnt_ena_q, cnt_ena_d;
  logic          cnt_rst_q, cnt_rst_d;
  logic          done_q, done_d;
  logic [3:0]    blink_q, blink_d;
  logic          at_term;

  assign at_term = (qdata == TERMINAL);

  always_comb begin
    state_d     = state_q;
    presc_d     = '0;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    cnt_ena_d   = 1'b0;
    cnt_rst_d   = clear;
    done_d      = 1'b0;
    blink_d     = 4'b0000;

    case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop)         state_d = PAUSE;
        else if (at_term) state_d = DONE;
      end
      PAUSE:   if (start && !stop) state_d = RUN;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;

    // Prescaler only advances across consecutive RUN cycles, so every resume starts a full period
    if (state_q == RUN && state_d == RUN)
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;

    cnt_ena_d = (state_q == RUN) && (presc_q == PRESC_MAX) && !at_term && !clear && !stop;

    if (state_d == DONE) begin
      done_d = 1'b1;
      if (state_q != DONE) begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
      blink_d = phase_d ? 4'b1111 : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      cnt_ena_q   <= 1'b0;
      cnt_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      blink_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      cnt_ena_q   <= cnt_ena_d;
      cnt_rst_q   <= cnt_rst_d;
      done_q      <= done_d;
      blink_q     <= blink_d;
    end
  end

  assign state   = state_q;
  assign cnt_ena = cnt_ena_q;
  assign cnt_rst = cnt_rst_q;
  assign done    = done_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_count_run_sequencer.sv
// Testbench for count_run_sequencer: hand-written vector table for reset/start,
// then a cycle model feeding a scoreboard queue for the multi-cycle sequences.
module tb_count_run_sequencer;

  localparam int          TICK_DIV  = 4;
  localparam int          BLINK_DIV = 8;
  localparam logic [15:0] TERM      = 16'h9675;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] qdata = 16'h0000;
  logic        cnt_ena;
  logic        cnt_rst;
  logic [1:0]  state;
  logic        done;
  logic [3:0]  blink;

  count_run_sequencer #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .TERMINAL(TERM)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .qdata(qdata),
    .cnt_ena(cnt_ena), .cnt_rst(cnt_rst), .state(state), .done(done), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       ena;
    logic       crst;
    logic       dn;
    logic [3:0] blk;
  } exp_t;

  typedef struct {
    logic        r, s, p, c;
    logic [15:0] q;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: cycles spent in the current RUN / DONE stint
  logic [1:0] m_state = 2'b00;
  int         m_run_cnt = 0;
  int         m_done_cnt = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_step(input logic r, s, p, c, input logic [15:0] q);
    exp_t       e;
    logic [1:0] nxt;
    if (r) begin
      e = '{2'b00, 1'b0, 1'b1, 1'b0, 4'b0000};
      m_state = 2'b00; m_run_cnt = 0; m_done_cnt = 0;
      return e;
    end
    nxt = m_state;
    if (c) nxt = 2'b00;
    else if (m_state == 2'b00 && s && !p) nxt = 2'b01;
    else if (m_state == 2'b01 && p) nxt = 2'b10;
    else if (m_state == 2'b01 && q == TERM) nxt = 2'b11;
    else if (m_state == 2'b10 && s && !p) nxt = 2'b01;
    e.st   = nxt;
    e.crst = c;
    e.ena  = (m_state == 2'b01) && !c && !p && (q != TERM) &&
             ((m_run_cnt % TICK_DIV) == TICK_DIV - 1);
    e.dn   = (nxt == 2'b11);
    if (nxt == 2'b11) m_done_cnt = (m_state == 2'b11) ? m_done_cnt + 1 : 0;
    else m_done_cnt = 0;
    e.blk  = (nxt == 2'b11 && ((m_done_cnt / BLINK_DIV) % 2 == 0)) ? 4'b1111 : 4'b0000;
    m_run_cnt = (nxt == 2'b01 && m_state == 2'b01) ? m_run_cnt + 1 : 0;
    m_state = nxt;
    return e;
  endfunction

  // Drives one cycle of inputs, queues the expectation, then checks after the edge
  task automatic applyStimulus(input logic r, s, p, c, input logic [15:0] q,
                               input bit use_tbl, input exp_t te);
    exp_t me, got;
    @(negedge clk);
    rst = r; start = s; stop = p; clear = c; qdata = q;
    me = model_step(r, s, p, c, q);
    sb_q.push_back(use_tbl ? te : me);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      got = sb_q.pop_front();
      checkOutput("state",   int'(state),   int'(got.st));
      checkOutput("cnt_ena", int'(cnt_ena), int'(got.ena));
      checkOutput("cnt_rst", int'(cnt_rst), int'(got.crst));
      checkOutput("done",    int'(done),    int'(got.dn));
      checkOutput("blink",   int'(blink),   int'(got.blk));
    end
  endtask

  task automatic go(input logic r, s, p, c, input logic [15:0] q);
    exp_t dummy;
    dummy = '{2'b00, 1'b0, 1'b0, 1'b0, 4'b0000};
    applyStimulus(r, s, p, c, q, 1'b0, dummy);
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] q);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0, 1'b0, 1'b0, q);
  endtask

  vec_t tbl[13];

  initial begin
    // Reset 3 cycles, start pulse, first cnt_ena 4 cycles into RUN then every 4
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, '{2'b00, 0, 1, 0, 4'h0}};
    tbl[1]  = '{1, 0, 0, 0, 16'h0000, '{2'b00, 0, 1, 0, 4'h0}};
    tbl[2]  = '{1, 0, 0, 0, 16'h0000, '{2'b00, 0, 1, 0, 4'h0}};
    tbl[3]  = '{0, 0, 0, 0, 16'h0000, '{2'b00, 0, 0, 0, 4'h0}};
    tbl[4]  = '{0, 1, 0, 0, 16'h0000, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[5]  = '{0, 0, 0, 0, 16'h0000, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[6]  = '{0, 0, 0, 0, 16'h0001, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[7]  = '{0, 0, 0, 0, 16'h0001, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[8]  = '{0, 0, 0, 0, 16'h0001, '{2'b01, 1, 0, 0, 4'h0}};
    tbl[9]  = '{0, 0, 0, 0, 16'h0002, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[10] = '{0, 0, 0, 0, 16'h0002, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[11] = '{0, 0, 0, 0, 16'h0002, '{2'b01, 0, 0, 0, 4'h0}};
    tbl[12] = '{0, 0, 0, 0, 16'h0002, '{2'b01, 1, 0, 0, 4'h0}};

    for (int i = 0; i < 13; i++)
      applyStimulus(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].q, 1'b1, tbl[i].e);

    // Pause for a while, then resume and run two full periods
    go(0, 0, 0, 0, 16'h0003);
    go(0, 0, 1, 0, 16'h0003);
    idle_cycles(6, 16'h0003);
    go(0, 1, 0, 0, 16'h0003);
    idle_cycles(9, 16'h0004);

    // start, stop and clear together in RUN: clear wins
    go(0, 1, 1, 1, 16'h0005);
    idle_cycles(2, 16'h0000);

    // Terminal arrives exactly on the tick cycle
    go(0, 1, 0, 0, 16'h0000);
    idle_cycles(3, 16'h9674);
    go(0, 0, 0, 0, TERM);

    // DONE blink pattern with start/stop pokes that must be ignored
    for (int i = 0; i < 20; i++)
      go(0, (i % 5) == 2, (i % 7) == 3, 0, TERM);

    // Held clear in DONE
    for (int i = 0; i < 5; i++) go(0, 0, 0, 1, TERM);
    idle_cycles(2, 16'h0000);

    // Reset mid-RUN at prescaler 2, then a fresh start gets a full period
    go(0, 1, 0, 0, 16'h0100);
    idle_cycles(2, 16'h0100);
    go(1, 0, 0, 0, 16'h0100);
    go(0, 1, 0, 0, 16'h0100);
    idle_cycles(9, 16'h0101);

    if (sb_q.size() != 0) checkOutput("scoreboard_leftover", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
